// File: rtl/imm_pack_encoder_pkg.sv
// imm_enc_pkg: ImmSrc codes, error codes, NOP word and range helper shared by the encoder files
package imm_enc_pkg;
   localparam logic [2:0] I_TYPE    = 3'd0;
   localparam logic [2:0] S_TYPE    = 3'd1;
   localparam logic [2:0] B_TYPE    = 3'd2;
   localparam logic [2:0] JALR_TYPE = 3'd3;
   localparam logic [2:0] JAL_TYPE  = 3'd4;
   localparam logic [2:0] LUI_TYPE  = 3'd5;
   localparam logic [1:0] ERR_NONE     = 2'b00;
   localparam logic [1:0] ERR_RANGE    = 2'b01;
   localparam logic [1:0] ERR_MISALIGN = 2'b10;
   localparam logic [1:0] ERR_BADTYPE  = 2'b11;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
   // true when v[31:lsb] are all zeros or all ones, i.e. v sign-extends from bit lsb
   function automatic logic upper_eq(input logic [31:0] v, input int unsigned lsb);
      return ((v >> lsb) == 32'h0) || (32'($signed(v) >>> lsb) == 32'hFFFF_FFFF);
   endfunction
endpackage

// File: rtl/imm_pack_encoder_if.sv
// imm_pack_encoder_if: loader-side input fields plus memory-side output word, error and wrap status
interface imm_pack_encoder_if #(parameter int ADDR_W = 10);
   logic              in_valid;
   logic              in_ready;
   logic [2:0]        ImmSrc;
   logic [31:0]       imm;
   logic [6:0]        opcode;
   logic [4:0]        rd;
   logic [4:0]        rs1;
   logic [4:0]        rs2;
   logic [2:0]        funct3;
   logic [6:0]        funct7;
   logic              out_valid;
   logic              out_ready;
   logic [31:0]       out_instr;
   logic [ADDR_W-1:0] out_addr;
   logic              err_valid;
   logic [1:0]        err_code;
   logic              wrapped;
   modport master (
      output in_valid, ImmSrc, imm, opcode, rd, rs1, rs2, funct3, funct7, out_ready,
      input  in_ready, out_valid, out_instr, out_addr, err_valid, err_code, wrapped
   );
   modport slave (
      input  in_valid, ImmSrc, imm, opcode, rd, rs1, rs2, funct3, funct7, out_ready,
      output in_ready, out_valid, out_instr, out_addr, err_valid, err_code, wrapped
   );
endinterface

// File: rtl/imm_pack_encoder_imm_pack.sv
// imm_pack: combinational RV32I field packing of an immediate plus its representability check
module imm_pack
   import imm_enc_pkg::*;
(
   input  logic [2:0]  imm_src,
   input  logic [31:0] imm,
   input  logic [6:0]  opcode,
   input  logic [4:0]  rd,
   input  logic [4:0]  rs1,
   input  logic [4:0]  rs2,
   input  logic [2:0]  funct3,
   output logic [31:0] instr,
   output logic        err,
   output logic [1:0]  code
);
   logic fits;
   logic bad;
   logic mis;
   // scatter immediate bits per format, then rank bad type > misalignment > range
   always_comb begin
      instr = 32'h0;
      fits  = 1'b0;
      case (imm_src)
         I_TYPE, JALR_TYPE: begin
            instr = {imm[11:0], rs1, funct3, rd, opcode};
            fits  = upper_eq(imm, 11);
         end
         S_TYPE: begin
            instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            fits  = upper_eq(imm, 11);
         end
         B_TYPE: begin
            instr = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
            fits  = upper_eq(imm, 12);
         end
         JAL_TYPE: begin
            instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
            fits  = upper_eq(imm, 20);
         end
         LUI_TYPE: begin
            instr = {imm[31:12], rd, opcode};
            fits  = imm[11:0] == 12'h000;
         end
         default: ;
      endcase
      bad  = imm_src > LUI_TYPE;
      mis  = (imm_src == B_TYPE || imm_src == JAL_TYPE) && imm[0];
      code = bad ? ERR_BADTYPE : mis ? ERR_MISALIGN : !fits ? ERR_RANGE : ERR_NONE;
      err  = code != ERR_NONE;
   end
endmodule

// File: rtl/imm_pack_encoder.sv
// imm_pack_encoder: streams packed RV32I words to instruction memory with auto-incrementing address.
// Build option IMM_ERR_NOP_EN: rejected inputs emit a NOP word instead of being dropped.
module imm_pack_encoder
   import imm_enc_pkg::*;
#(
   parameter int ADDR_W    = 10,
   parameter int BASE_ADDR = 0
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   imm_pack_encoder_if.slave   bus
);
`ifdef IMM_ERR_NOP_EN
   localparam bit NOP_EN = 1'b1;
`else
   localparam bit NOP_EN = 1'b0;
`endif
   localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
   logic [31:0]       pk_instr;
   logic              pk_err;
   logic [1:0]        pk_code;
   logic              in_rdy, acc, out_hs, emit;
   logic              out_valid_q, out_valid_d;
   logic [31:0]       out_instr_q, out_instr_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              err_valid_q, err_valid_d;
   logic [1:0]        err_code_q, err_code_d;
   logic              wrapped_q, wrapped_d;
   logic              unused_funct7;
   assign unused_funct7 = ^bus.funct7;
   imm_pack u_pack (
      .imm_src(bus.ImmSrc),
      .imm    (bus.imm),
      .opcode (bus.opcode),
      .rd     (bus.rd),
      .rs1    (bus.rs1),
      .rs2    (bus.rs2),
      .funct3 (bus.funct3),
      .instr  (pk_instr),
      .err    (pk_err),
      .code   (pk_code)
   );
   // handshake decode and next state; start flushes the word and rewinds the address ahead of any handshake
   always_comb begin
      in_rdy      = !start && (!out_valid_q || bus.out_ready);
      acc         = bus.in_valid && in_rdy;
      out_hs      = out_valid_q && bus.out_ready;
      emit        = acc && (!pk_err || NOP_EN);
      out_valid_d = !start && (emit || (out_valid_q && !bus.out_ready));
      out_instr_d = emit ? (pk_err ? NOP_INSTR : pk_instr) : out_instr_q;
      addr_d      = start ? BASE : out_hs ? addr_q + 1'b1 : addr_q;
      wrapped_d   = !start && (wrapped_q || (out_hs && &addr_q));
      err_valid_d = acc && pk_err;
      err_code_d  = err_valid_d ? pk_code : err_code_q;
   end
   // output word, address counter and error status registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_instr_q <= 32'h0;
         addr_q      <= BASE;
         err_valid_q <= 1'b0;
         err_code_q  <= ERR_NONE;
         wrapped_q   <= 1'b0;
      end else begin
         out_valid_q <= out_valid_d;
         out_instr_q <= out_instr_d;
         addr_q      <= addr_d;
         err_valid_q <= err_valid_d;
         err_code_q  <= err_code_d;
         wrapped_q   <= wrapped_d;
      end
   end
   assign bus.in_ready  = in_rdy;
   assign bus.out_valid = out_valid_q;
   assign bus.out_instr = out_instr_q;
   assign bus.out_addr  = addr_q;
   assign bus.err_valid = err_valid_q;
   assign bus.err_code  = err_code_q;
   assign bus.wrapped   = wrapped_q;
endmodule

// File: tb/tb_imm_pack_encoder.sv
// tb_imm_pack_encoder: table vectors, hand-written corner sequences and random traffic against a queue model
module tb_imm_pack_encoder;
   localparam int AW = 2;
`ifdef IMM_ERR_NOP_EN
   localparam bit NOP_EN = 1'b1;
`else
   localparam bit NOP_EN = 1'b0;
`endif
   localparam logic [31:0] NOP_W = 32'h0000_0013;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;
   imm_pack_encoder_if #(.ADDR_W(AW)) bus();
   imm_pack_encoder #(.ADDR_W(AW), .BASE_ADDR(0)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .start(start),
      .bus  (bus)
   );
   always #5 clk = ~clk;
   int n_cmp = 0;
   int n_bad = 0;
   logic [31:0] exp_q[$];
   int exp_addr = 0;
   bit wrap_m = 1'b0;
   bit errp_m = 1'b0;
   logic [1:0] code_m = 2'b00;
   typedef struct {
      logic [2:0]  src;
      logic [31:0] imm;
      logic [4:0]  rs1, rs2, rd;
      logic [2:0]  f3;
      logic [6:0]  op;
      bit          err;
      logic [1:0]  code;
      logic [31:0] instr;
   } vec_t;
   vec_t tv[11];
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask
   // reference: legality from signed value ranges, encoding placed straight from the format tables
   function automatic void ref_enc(input logic [2:0] src, input logic [31:0] imm, input logic [4:0] rs1,
                                   input logic [4:0] rs2, input logic [4:0] rd, input logic [2:0] f3,
                                   input logic [6:0] op, output bit ok, output logic [1:0] code,
                                   output logic [31:0] w);
      int v;
      bit in_rng;
      v = imm;
      in_rng = 1'b0;
      w = 32'h0;
      case (src)
         3'd0, 3'd3: begin in_rng = v >= -2048 && v <= 2047; w = {imm[11:0], rs1, f3, rd, op}; end
         3'd1: begin in_rng = v >= -2048 && v <= 2047; w = {imm[11:5], rs2, rs1, f3, imm[4:0], op}; end
         3'd2: begin in_rng = v >= -4096 && v <= 4095; w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op}; end
         3'd4: begin in_rng = v >= -(1 << 20) && v < (1 << 20); w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op}; end
         3'd5: begin in_rng = (imm % 4096) == 0; w = {imm[31:12], rd, op}; end
         default: in_rng = 1'b0;
      endcase
      code = src > 3'd5 ? 2'b11 : ((src == 3'd2 || src == 3'd4) && (v % 2) != 0) ? 2'b10 : !in_rng ? 2'b01 : 2'b00;
      ok = code == 2'b00;
   endfunction
   task automatic set_f(input logic [2:0] src, input logic [31:0] imm, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic [2:0] f3, input logic [6:0] op);
      bus.ImmSrc = src;
      bus.imm    = imm;
      bus.rs1    = rs1;
      bus.rs2    = rs2;
      bus.rd     = rd;
      bus.funct3 = f3;
      bus.opcode = op;
      bus.funct7 = 7'($urandom);
   endtask
   // drive one cycle from a negedge, advance the model across the posedge, compare at the next negedge
   task automatic step(input bit iv, input bit ordy, input bit st);
      bit ok;
      bit acc;
      logic [1:0] c;
      logic [31:0] w;
      bus.in_valid  = iv;
      bus.out_ready = ordy;
      start         = st;
      #1;
      chk("in_ready", 32'(bus.in_ready), 32'(!st && (exp_q.size() == 0 || ordy)));
      acc = iv && bus.in_ready;
      ref_enc(bus.ImmSrc, bus.imm, bus.rs1, bus.rs2, bus.rd, bus.funct3, bus.opcode, ok, c, w);
      if (st) begin
         exp_q.delete();
         exp_addr = 0;
         wrap_m = 1'b0;
      end else if (exp_q.size() > 0 && ordy) begin
         void'(exp_q.pop_front());
         if (exp_addr == (1 << AW) - 1) begin
            exp_addr = 0;
            wrap_m = 1'b1;
         end else exp_addr++;
      end
      errp_m = acc && !ok;
      if (acc && !ok) code_m = c;
      if (acc && (ok || NOP_EN)) exp_q.push_back(ok ? w : NOP_W);
      @(negedge clk);
      start = 1'b0;
      chk("out_valid", 32'(bus.out_valid), 32'(exp_q.size() > 0));
      if (exp_q.size() > 0) begin
         chk("out_instr", bus.out_instr, exp_q[0]);
         chk("out_addr", 32'(bus.out_addr), 32'(exp_addr));
      end
      chk("err_valid", 32'(bus.err_valid), 32'(errp_m));
      chk("err_code", 32'(bus.err_code), 32'(code_m));
      chk("wrapped", 32'(bus.wrapped), 32'(wrap_m));
   endtask
   initial begin
      logic [31:0] i0;
      logic [AW-1:0] a0;
      logic [31:0] rimm;
      tv[0]  = '{3'd0, 32'd5,         5'd0, 5'd0, 5'd1, 3'd0, 7'h13, 1'b0, 2'b00, 32'h0050_0093};
      tv[1]  = '{3'd2, -32'sd8,       5'd1, 5'd2, 5'd0, 3'd0, 7'h63, 1'b0, 2'b00, 32'hFE20_8CE3};
      tv[2]  = '{3'd4, 32'h800,       5'd0, 5'd0, 5'd1, 3'd0, 7'h6F, 1'b0, 2'b00, 32'h0010_00EF};
      tv[3]  = '{3'd5, 32'h1234_5000, 5'd0, 5'd0, 5'd5, 3'd0, 7'h37, 1'b0, 2'b00, 32'h1234_52B7};
      tv[4]  = '{3'd0, 32'd2048,      5'd0, 5'd0, 5'd1, 3'd0, 7'h13, 1'b1, 2'b01, 32'h0};
      tv[5]  = '{3'd2, 32'd3,         5'd1, 5'd2, 5'd0, 3'd0, 7'h63, 1'b1, 2'b10, 32'h0};
      tv[6]  = '{3'd7, 32'd0,         5'd0, 5'd0, 5'd0, 3'd0, 7'h13, 1'b1, 2'b11, 32'h0};
      tv[7]  = '{3'd0, 32'hFFFF_F800, 5'd0, 5'd0, 5'd1, 3'd0, 7'h13, 1'b0, 2'b00, 32'h8000_0093};
      tv[8]  = '{3'd1, 32'hFFFF_FFFF, 5'd2, 5'd3, 5'd0, 3'd2, 7'h23, 1'b0, 2'b00, 32'hFE31_2FA3};
      tv[9]  = '{3'd5, 32'h1234_5001, 5'd0, 5'd0, 5'd5, 3'd0, 7'h37, 1'b1, 2'b01, 32'h0};
      tv[10] = '{3'd4, 32'd1,         5'd0, 5'd0, 5'd1, 3'd0, 7'h6F, 1'b1, 2'b10, 32'h0};
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      set_f(3'd0, 32'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'h13);
      #12;
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_out_instr", bus.out_instr, 32'd0);
      chk("rst_out_addr", 32'(bus.out_addr), 32'd0);
      chk("rst_err_valid", 32'(bus.err_valid), 32'd0);
      chk("rst_err_code", 32'(bus.err_code), 32'd0);
      chk("rst_wrapped", 32'(bus.wrapped), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 11; i++) begin
         a0 = bus.out_addr;
         set_f(tv[i].src, tv[i].imm, tv[i].rs1, tv[i].rs2, tv[i].rd, tv[i].f3, tv[i].op);
         step(1'b1, 1'b1, 1'b0);
         if (tv[i].err) begin
            chk("tbl_err_valid", 32'(bus.err_valid), 32'd1);
            chk("tbl_err_code", 32'(bus.err_code), 32'(tv[i].code));
            chk("tbl_err_out_valid", 32'(bus.out_valid), 32'(NOP_EN));
         end else begin
            chk("tbl_out_valid", 32'(bus.out_valid), 32'd1);
            chk("tbl_instr", bus.out_instr, tv[i].instr);
            chk("tbl_addr", 32'(bus.out_addr), 32'(a0));
         end
         step(1'b0, 1'b1, 1'b0);
         chk("tbl_addr_next", 32'(bus.out_addr), 32'(AW'(a0 + ((tv[i].err && !NOP_EN) ? 0 : 1))));
      end
      // backpressure: word held stable, new input refused, then both words drain in order
      step(1'b0, 1'b1, 1'b1);
      set_f(3'd0, 32'd1, 5'd0, 5'd0, 5'd2, 3'd0, 7'h13);
      step(1'b1, 1'b0, 1'b0);
      i0 = bus.out_instr;
      a0 = bus.out_addr;
      set_f(3'd0, 32'd2, 5'd0, 5'd0, 5'd3, 3'd0, 7'h13);
      for (int k = 0; k < 3; k++) begin
         step(1'b1, 1'b0, 1'b0);
         chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
         chk("bp_instr_stable", bus.out_instr, i0);
         chk("bp_addr_stable", 32'(bus.out_addr), 32'(a0));
      end
      step(1'b1, 1'b1, 1'b0);
      chk("bp_second_word", bus.out_instr, 32'h0020_0193);
      chk("bp_second_addr", 32'(bus.out_addr), 32'(AW'(a0 + 1)));
      step(1'b0, 1'b1, 1'b0);
      // wrap: five words land at 0,1,2,3,0; then start discards the pending word
      step(1'b0, 1'b1, 1'b1);
      for (int k = 0; k < 5; k++) begin
         set_f(3'd0, 32'(k), 5'd1, 5'd0, 5'd4, 3'd0, 7'h13);
         step(1'b1, 1'b1, 1'b0);
         chk("wrap_addr", 32'(bus.out_addr), 32'(k % 4));
      end
      chk("wrap_flag", 32'(bus.wrapped), 32'd1);
      step(1'b0, 1'b1, 1'b1);
      chk("start_out_valid", 32'(bus.out_valid), 32'd0);
      chk("start_addr", 32'(bus.out_addr), 32'd0);
      chk("start_wrapped", 32'(bus.wrapped), 32'd0);
      for (int n = 0; n < 600; n++) begin
         case ($urandom % 4)
            0: rimm = 32'($urandom_range(0, 16383)) - 32'd8192;
            1: rimm = 32'($urandom_range(0, 1)) ? 32'hFFFF_F800 - 32'($urandom_range(0, 1)) : 32'd2047 + 32'($urandom_range(0, 1));
            2: rimm = $urandom & 32'hFFFF_F000;
            default: rimm = $urandom;
         endcase
         set_f(3'($urandom), rimm, 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), 7'($urandom));
         step($urandom % 4 != 0, $urandom % 4 != 0, $urandom % 40 == 0);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
